// File: rtl/dp_pack.sv
// Sample packer: groups PKT_LEN 24-bit samples into a framed, checksummed byte packet
// stamped with the first sample's time, using a ping-pong buffer and a valid/ready byte stream.
module dp_pack #(
  parameter int unsigned PKT_LEN = 16,
  parameter logic [7:0]  SYNC0   = 8'hA5,
  parameter logic [7:0]  SYNC1   = 8'h5A
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        pk_en,
  input  logic [23:0] dp_data,
  input  logic        dp_vld,
  input  logic [31:0] dp_utc,
  input  logic [31:0] dp_ns,
  output logic [7:0]  pk_data,
  output logic        pk_vld,
  input  logic        pk_rdy,
  output logic        pk_sop,
  output logic        pk_eop,
  output logic [15:0] ovf_cnt
);

  localparam int unsigned IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned AW = $clog2(2 * PKT_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC0, S_SYNC1, S_SEQ, S_UTC, S_NS, S_DATA, S_SUM
  } state_t;

  // sample storage and per-bank timestamps
  logic [23:0]   r_mem [2*PKT_LEN];
  logic [23:0]   r_rd_q;
  logic [31:0]   r_utc [2];
  logic [31:0]   r_ns  [2];
  logic [1:0]    r_full;

  // capture side
  logic          r_cap_bank;
  logic [IW-1:0] r_fill_idx;
  logic [15:0]   r_ovf;

  // sender side
  state_t        r_state;
  logic          r_snd_bank;
  logic [2:0]    r_cnt;
  logic [1:0]    r_byte;
  logic [IW-1:0] r_smp;
  logic [IW-1:0] r_rd_idx;
  logic [23:0]   r_samp;
  logic [7:0]    r_sum;
  logic [7:0]    r_seq;
  logic [7:0]    r_pk_data;
  logic          r_pk_vld;
  logic          r_pk_sop;
  logic          r_pk_eop;

  logic          w_accept;
  logic          w_release;
  logic          w_cap;
  logic          w_cap_blocked;
  logic          w_wr_en;
  logic          w_fill_done;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;
  logic [IW-1:0] w_rd_idx_nxt;
  logic [31:0]   w_utc_s;
  logic [31:0]   w_ns_s;
  logic          w_last_smp;
  logic [7:0]    w_nxt_byte;

  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  assign pk_data = r_pk_data;
  assign pk_vld  = r_pk_vld;
  assign pk_sop  = r_pk_sop;
  assign pk_eop  = r_pk_eop;
  assign ovf_cnt = r_ovf;

  assign w_accept  = r_pk_vld && pk_rdy;
  assign w_release = w_accept && (r_state == S_SUM);
  assign w_cap     = dp_vld && pk_en;
  // a bank freed this very cycle already accepts the incoming sample
  assign w_cap_blocked = r_full[r_cap_bank] && !(w_release && (r_snd_bank == r_cap_bank));
  assign w_wr_en     = w_cap && !w_cap_blocked;
  assign w_fill_done = w_wr_en && (r_fill_idx == LAST_IDX);

  assign w_wr_addr = r_cap_bank ? AW'(PKT_LEN + 32'(r_fill_idx)) : AW'(r_fill_idx);
  assign w_rd_addr = r_snd_bank ? AW'(PKT_LEN + 32'(r_rd_idx))   : AW'(r_rd_idx);
  assign w_rd_idx_nxt = (r_rd_idx == LAST_IDX) ? r_rd_idx : r_rd_idx + 1'b1;

  assign w_utc_s    = r_utc[r_snd_bank];
  assign w_ns_s     = r_ns[r_snd_bank];
  assign w_last_smp = (r_smp == LAST_IDX);

  // sample buffer: independent write port and registered read port
  always_ff @(posedge clk_sys) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= dp_data;
    end
    r_rd_q <= r_mem[w_rd_addr];
  end

  // capture: fill index, bank toggle, timestamp latch, overflow count
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_bank <= 1'b0;
      r_fill_idx <= '0;
      r_utc[0]   <= '0;
      r_utc[1]   <= '0;
      r_ns[0]    <= '0;
      r_ns[1]    <= '0;
      r_ovf      <= '0;
    end else if (!pk_en) begin
      r_fill_idx <= '0;
    end else if (w_wr_en) begin
      if (r_fill_idx == '0) begin
        r_utc[r_cap_bank] <= dp_utc;
        r_ns[r_cap_bank]  <= dp_ns;
      end
      if (r_fill_idx == LAST_IDX) begin
        r_fill_idx <= '0;
        r_cap_bank <= ~r_cap_bank;
      end else begin
        r_fill_idx <= r_fill_idx + 1'b1;
      end
    end else if (w_cap && (r_ovf != 16'hFFFF)) begin
      r_ovf <= r_ovf + 16'd1;
    end
  end

  // bank ownership: capture marks full, sender marks empty
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
    end else begin
      if (w_release) begin
        r_full[r_snd_bank] <= 1'b0;
      end
      if (w_fill_done) begin
        r_full[r_cap_bank] <= 1'b1;
      end
    end
  end

  // byte to present after the current one is accepted
  always_comb begin
    w_nxt_byte = '0;
    case (r_state)
      S_SYNC0: w_nxt_byte = SYNC1;
      S_SYNC1: w_nxt_byte = r_seq;
      S_SEQ:   w_nxt_byte = be_byte(w_utc_s, 2'd0);
      S_UTC:   w_nxt_byte = (r_cnt == 3'd4) ? be_byte(w_ns_s, 2'd0)
                                            : be_byte(w_utc_s, r_cnt[1:0]);
      S_NS:    w_nxt_byte = (r_cnt == 3'd4) ? r_rd_q[23:16]
                                            : be_byte(w_ns_s, r_cnt[1:0]);
      S_DATA: begin
        case (r_byte)
          2'd1:    w_nxt_byte = r_samp[15:8];
          2'd2:    w_nxt_byte = r_samp[7:0];
          default: w_nxt_byte = w_last_smp ? r_sum : r_rd_q[23:16];
        endcase
      end
      default: w_nxt_byte = '0;
    endcase
  end

  // sender FSM; the next sample is latched from the read port as its MSB byte goes out
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_snd_bank <= 1'b0;
      r_cnt      <= '0;
      r_byte     <= '0;
      r_smp      <= '0;
      r_rd_idx   <= '0;
      r_samp     <= '0;
      r_sum      <= '0;
      r_seq      <= '0;
      r_pk_data  <= '0;
      r_pk_vld   <= 1'b0;
      r_pk_sop   <= 1'b0;
      r_pk_eop   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (r_full[r_snd_bank]) begin
        r_pk_data <= SYNC0;
        r_pk_vld  <= 1'b1;
        r_pk_sop  <= 1'b1;
        r_rd_idx  <= '0;
        r_state   <= S_SYNC0;
      end
    end else if (w_accept) begin
      r_pk_data <= w_nxt_byte;
      r_sum     <= (r_state == S_SYNC1) ? r_seq : r_sum + w_nxt_byte;
      case (r_state)
        S_SYNC0: begin
          r_pk_sop <= 1'b0;
          r_state  <= S_SYNC1;
        end
        S_SYNC1: r_state <= S_SEQ;
        S_SEQ: begin
          r_cnt   <= 3'd1;
          r_state <= S_UTC;
        end
        S_UTC: begin
          if (r_cnt == 3'd4) begin
            r_cnt   <= 3'd1;
            r_state <= S_NS;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_NS: begin
          if (r_cnt == 3'd4) begin
            r_samp   <= r_rd_q;
            r_rd_idx <= w_rd_idx_nxt;
            r_smp    <= '0;
            r_byte   <= 2'd1;
            r_state  <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_DATA: begin
          case (r_byte)
            2'd1:    r_byte <= 2'd2;
            2'd2:    r_byte <= 2'd3;
            default: begin
              if (w_last_smp) begin
                r_pk_eop <= 1'b1;
                r_state  <= S_SUM;
              end else begin
                r_samp   <= r_rd_q;
                r_rd_idx <= w_rd_idx_nxt;
                r_smp    <= r_smp + 1'b1;
                r_byte   <= 2'd1;
              end
            end
          endcase
        end
        S_SUM: begin
          r_pk_vld   <= 1'b0;
          r_pk_eop   <= 1'b0;
          r_seq      <= r_seq + 8'd1;
          r_snd_bank <= ~r_snd_bank;
          r_rd_idx   <= '0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_pack.sv
// Scoreboard bench for dp_pack with PKT_LEN=4: expected packet bytes are queued when
// samples are driven and checked as the DUT hands them over.
module tb_dp_pack;

  localparam int N  = 4;
  localparam int PB = 12 + 3 * N;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        pk_en   = 1'b0;
  logic [23:0] dp_data = '0;
  logic        dp_vld  = 1'b0;
  logic [31:0] dp_utc  = '0;
  logic [31:0] dp_ns   = '0;
  logic [7:0]  pk_data;
  logic        pk_vld;
  logic        pk_rdy  = 1'b0;
  logic        pk_sop;
  logic        pk_eop;
  logic [15:0] ovf_cnt;

  dp_pack #(.PKT_LEN(N), .SYNC0(8'hA5), .SYNC1(8'h5A)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .pk_en   (pk_en),
    .dp_data (dp_data),
    .dp_vld  (dp_vld),
    .dp_utc  (dp_utc),
    .dp_ns   (dp_ns),
    .pk_data (pk_data),
    .pk_vld  (pk_vld),
    .pk_rdy  (pk_rdy),
    .pk_sop  (pk_sop),
    .pk_eop  (pk_eop),
    .ovf_cnt (ovf_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [9:0]  sb_q[$];
  logic [7:0]  exp_seq = 8'h00;
  logic [23:0] smp [N];
  int          rdy_mode = 0;
  logic        mon_en = 1'b0;
  int          rx_idx = 0;
  logic        in_pkt = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data;
  logic        prev_sop;
  logic        prev_eop;
  logic        mon_r;
  logic [9:0]  mon_exp;

  // monitor: drives pk_rdy, checks hold-while-stalled, in-packet gaps and byte order
  always @(negedge clk_sys) begin
    if (!mon_en) begin
      prev_stall = 1'b0;
      in_pkt     = 1'b0;
      pk_rdy     = 1'b0;
    end else begin
      if (prev_stall) begin
        n_total++;
        if (pk_vld !== 1'b1 || pk_data !== prev_data || pk_sop !== prev_sop || pk_eop !== prev_eop) begin
          n_bad++;
          $display("FAIL stall_hold: got vld=%b data=%h sop=%b eop=%b, need vld=1 data=%h sop=%b eop=%b",
                   pk_vld, pk_data, pk_sop, pk_eop, prev_data, prev_sop, prev_eop);
        end
      end
      if (rdy_mode == 0 && in_pkt) begin
        n_total++;
        if (pk_vld !== 1'b1) begin
          n_bad++;
          $display("FAIL pkt_gap: got vld=%b inside packet at byte %0d, need 1", pk_vld, rx_idx);
        end
      end
      case (rdy_mode)
        0:       mon_r = 1'b1;
        1:       mon_r = 1'($urandom_range(0, 1));
        default: mon_r = 1'b0;
      endcase
      pk_rdy = mon_r;
      if (pk_vld === 1'b1 && mon_r) begin
        n_total++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_byte: got data=%h sop=%b eop=%b, need no byte", pk_data, pk_sop, pk_eop);
        end else begin
          mon_exp = sb_q.pop_front();
          if ({pk_sop, pk_eop, pk_data} !== mon_exp) begin
            n_bad++;
            $display("FAIL byte[%0d]: got sop=%b eop=%b data=%h, need sop=%b eop=%b data=%h",
                     rx_idx, pk_sop, pk_eop, pk_data, mon_exp[9], mon_exp[8], mon_exp[7:0]);
          end
        end
        rx_idx = pk_eop ? 0 : rx_idx + 1;
        in_pkt = !pk_eop;
      end
      prev_stall = (pk_vld === 1'b1) && !mon_r;
      prev_data  = pk_data;
      prev_sop   = pk_sop;
      prev_eop   = pk_eop;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, need completion");
    $fatal(1, "watchdog expired");
  end

  task automatic push_pkt(input logic [31:0] utc, input logic [31:0] ns);
    logic [7:0] pb [PB];
    logic [7:0] s;
    pb[0] = 8'hA5;
    pb[1] = 8'h5A;
    pb[2] = exp_seq;
    for (int i = 0; i < 4; i++) begin
      pb[3 + i] = 8'(utc >> (24 - 8 * i));
      pb[7 + i] = 8'(ns >> (24 - 8 * i));
    end
    for (int k = 0; k < N; k++) begin
      pb[11 + 3 * k] = smp[k][23:16];
      pb[12 + 3 * k] = smp[k][15:8];
      pb[13 + 3 * k] = smp[k][7:0];
    end
    s = 8'h00;
    for (int i = 2; i < PB - 1; i++) s = s + pb[i];
    pb[PB - 1] = s;
    for (int i = 0; i < PB; i++) sb_q.push_back({1'(i == 0), 1'(i == PB - 1), pb[i]});
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic send_sample(input logic [23:0] d, input logic [31:0] u, input logic [31:0] n, input int gap);
    @(negedge clk_sys);
    dp_vld  = 1'b1;
    dp_data = d;
    dp_utc  = u;
    dp_ns   = n;
    @(negedge clk_sys);
    dp_vld = 1'b0;
    repeat (gap) @(negedge clk_sys);
  endtask

  // later samples carry different timestamps so a wrong latch shows up
  task automatic send_pkt(input logic [31:0] utc, input logic [31:0] ns, input int gap, input bit push);
    if (push) push_pkt(utc, ns);
    for (int k = 0; k < N; k++) send_sample(smp[k], utc + 32'(k), ns + 32'(k * 7), gap);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int c;
    c = 0;
    while ((sb_q.size() != 0 || pk_vld !== 1'b0) && c < limit) begin
      @(negedge clk_sys);
      c++;
    end
    n_total++;
    if (sb_q.size() != 0 || pk_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d bytes outstanding vld=%b, need 0 and 0", name, sb_q.size(), pk_vld);
      sb_q.delete();
    end
    repeat (6) @(negedge clk_sys);
  endtask

  task automatic apply_reset();
    @(negedge clk_sys);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    sb_q.delete();
    exp_seq = 8'h00;
    rx_idx  = 0;
    repeat (2) @(negedge clk_sys);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    n_total++; if (pk_vld  !== 1'b0)   begin n_bad++; $display("FAIL rst_vld: got %b need 0", pk_vld); end
    n_total++; if (pk_data !== 8'h00)  begin n_bad++; $display("FAIL rst_data: got %h need 00", pk_data); end
    n_total++; if (pk_sop  !== 1'b0)   begin n_bad++; $display("FAIL rst_sop: got %b need 0", pk_sop); end
    n_total++; if (pk_eop  !== 1'b0)   begin n_bad++; $display("FAIL rst_eop: got %b need 0", pk_eop); end
    n_total++; if (ovf_cnt !== 16'h0)  begin n_bad++; $display("FAIL rst_ovf: got %h need 0000", ovf_cnt); end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(negedge clk_sys);
    n_total++; if (pk_vld !== 1'b0) begin n_bad++; $display("FAIL idle_vld: got %b need 0", pk_vld); end
  endtask

  task automatic test_t1_basic();
    logic [7:0] tbl [PB];
    int lat;
    tbl = '{8'hA5, 8'h5A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h03, 8'hE8,
            8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'hEF, 8'hFF, 8'hFF, 8'hFF, 8'h96};
    rdy_mode = 0;
    pk_en    = 1'b1;
    smp[0] = 24'h123456; smp[1] = 24'h000001; smp[2] = 24'hABCDEF; smp[3] = 24'hFFFFFF;
    for (int i = 0; i < PB; i++) sb_q.push_back({1'(i == 0), 1'(i == PB - 1), tbl[i]});
    exp_seq = exp_seq + 8'd1;
    send_pkt(32'h11223344, 32'h000003E8, 0, 1'b0);
    lat = 0;
    while (pk_vld !== 1'b1 && lat < 4) begin
      @(negedge clk_sys);
      lat++;
    end
    n_total++;
    if (pk_vld !== 1'b1 || lat > 1) begin
      n_bad++;
      $display("FAIL t1_latency: got vld=%b after %0d extra cycles, need vld=1 within 1", pk_vld, lat);
    end
    wait_drain("t1", 200);
    n_total++; if (ovf_cnt !== 16'h0) begin n_bad++; $display("FAIL t1_ovf: got %h need 0000", ovf_cnt); end
  endtask

  task automatic test_t2_stall();
    rdy_mode = 1;
    smp[0] = 24'h123456; smp[1] = 24'h000001; smp[2] = 24'hABCDEF; smp[3] = 24'hFFFFFF;
    send_pkt(32'h11223344, 32'h000003E8, 0, 1'b1);
    wait_drain("t2", 400);
    rdy_mode = 0;
  endtask

  task automatic test_t3_overflow();
    apply_reset();
    rdy_mode = 2;
    pk_en    = 1'b1;
    smp[0] = 24'h010203; smp[1] = 24'h040506; smp[2] = 24'h070809; smp[3] = 24'h0A0B0C;
    send_pkt(32'h00000100, 32'h00000010, 0, 1'b1);
    smp[0] = 24'h111111; smp[1] = 24'h222222; smp[2] = 24'h333333; smp[3] = 24'h444444;
    send_pkt(32'h00000200, 32'h00000020, 0, 1'b1);
    smp[0] = 24'hDEAD01; smp[1] = 24'hDEAD02; smp[2] = 24'hDEAD03; smp[3] = 24'hDEAD04;
    send_pkt(32'h00000300, 32'h00000030, 0, 1'b0);
    repeat (3) @(negedge clk_sys);
    n_total++; if (ovf_cnt !== 16'd4) begin n_bad++; $display("FAIL t3_ovf: got %0d need 4", ovf_cnt); end
    n_total++;
    if (pk_vld !== 1'b1 || pk_data !== 8'hA5 || pk_sop !== 1'b1) begin
      n_bad++;
      $display("FAIL t3_hold: got vld=%b data=%h sop=%b, need 1 A5 1", pk_vld, pk_data, pk_sop);
    end
    rdy_mode = 0;
    wait_drain("t3", 300);
    n_total++; if (ovf_cnt !== 16'd4) begin n_bad++; $display("FAIL t3_ovf_after: got %0d need 4", ovf_cnt); end
  endtask

  task automatic test_t4_enable();
    rdy_mode = 0;
    send_sample(24'hBAD001, 32'h0000AAAA, 32'h0000AAAA, 0);
    send_sample(24'hBAD002, 32'h0000BBBB, 32'h0000BBBB, 0);
    @(negedge clk_sys);
    pk_en = 1'b0;
    send_sample(24'hBAD003, 32'h0000CCCC, 32'h0000CCCC, 0);
    repeat (2) @(negedge clk_sys);
    pk_en = 1'b1;
    smp[0] = 24'h600001; smp[1] = 24'h600002; smp[2] = 24'h600003; smp[3] = 24'h600004;
    send_pkt(32'h5E5E0001, 32'h12345678, 1, 1'b1);
    wait_drain("t4", 200);
  endtask

  task automatic test_t5_wrap();
    apply_reset();
    rdy_mode = 0;
    pk_en    = 1'b1;
    for (int p = 0; p < 257; p++) begin
      for (int k = 0; k < N; k++) smp[k] = 24'($urandom);
      send_pkt(32'(p), $urandom, 6, 1'b1);
    end
    wait_drain("t5", 300);
    n_total++; if (ovf_cnt !== 16'h0) begin n_bad++; $display("FAIL t5_ovf: got %h need 0000", ovf_cnt); end
    n_total++; if (exp_seq !== 8'h01) begin n_bad++; $display("FAIL t5_seq_model: got %h need 01", exp_seq); end
  endtask

  task automatic test_t6_reset_mid();
    int c;
    rdy_mode = 1;
    smp[0] = 24'h700001; smp[1] = 24'h700002; smp[2] = 24'h700003; smp[3] = 24'h700004;
    send_pkt(32'h0000ABCD, 32'h00001234, 0, 1'b1);
    send_sample(24'hF00001, 32'h00000001, 32'h00000001, 0);
    send_sample(24'hF00002, 32'h00000002, 32'h00000002, 0);
    c = 0;
    while (rx_idx < 14 && c < 300) begin
      @(negedge clk_sys);
      c++;
    end
    n_total++;
    if (rx_idx < 14) begin
      n_bad++;
      $display("FAIL t6_reach_data: got byte index %0d, need >= 14", rx_idx);
    end
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (pk_vld !== 1'b0 || pk_data !== 8'h00 || pk_sop !== 1'b0 || pk_eop !== 1'b0) begin
      n_bad++;
      $display("FAIL t6_async_rst: got vld=%b data=%h sop=%b eop=%b, need 0 00 0 0", pk_vld, pk_data, pk_sop, pk_eop);
    end
    sb_q.delete();
    exp_seq = 8'h00;
    rx_idx  = 0;
    repeat (2) @(negedge clk_sys);
    rst_n    = 1'b1;
    mon_en   = 1'b1;
    rdy_mode = 0;
    repeat (4) @(negedge clk_sys);
    n_total++; if (pk_vld !== 1'b0) begin n_bad++; $display("FAIL t6_idle: got vld=%b need 0", pk_vld); end
    n_total++; if (ovf_cnt !== 16'h0) begin n_bad++; $display("FAIL t6_ovf: got %h need 0000", ovf_cnt); end
    smp[0] = 24'h800001; smp[1] = 24'h800002; smp[2] = 24'h800003; smp[3] = 24'h800004;
    send_pkt(32'h0F0F0F0F, 32'h3B9AC9FF, 0, 1'b1);
    wait_drain("t6", 200);
  endtask

  initial begin
    test_reset();
    test_t1_basic();
    test_t2_stall();
    test_t3_overflow();
    test_t4_enable();
    test_t5_wrap();
    test_t6_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
